// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default sync pattern for the frame deserializer
package seq_pkg;
   localparam logic [1:0] HUNT = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [3:0] SYNC_PAT_DEF = 4'b1101;
endpackage

// File: rtl/sync_match.sv
// sync_match: sliding sync window with a comparator that looks at the bit being shifted in
module sync_match
   import seq_pkg::*;
#(
   parameter int                SYNC_W   = 4,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic shift,
   input  logic flush,
   input  logic din,
   output logic hit
);
   logic [SYNC_W-1:0] sync_sr;
   logic [SYNC_W-1:0] win;
   assign win = {sync_sr[SYNC_W-2:0], din};
   assign hit = win == SYNC_PAT;
   // window advances only while hunting; a completed frame wipes any stale prefix
   always_ff @(posedge clk) begin
      if (clr || flush) sync_sr <= '0;
      else if (shift) sync_sr <= win;
   end
endmodule

// File: rtl/frame_deser.sv
// frame_deser: hunts for a sync word, then collects one DATA_W-bit payload per frame
module frame_deser
   import seq_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                SYNC_W   = 4,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic              din,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              locked,
   output logic [7:0]        frame_cnt
);
   localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] data_sr;
   logic              hit;
   assign valid  = state == DONE;
   assign locked = state == DATA;
   sync_match #(.SYNC_W(SYNC_W), .SYNC_PAT(SYNC_PAT)) u_sync (
      .clk  (clk),
      .clr  (clr),
      .shift(en && state == HUNT),
      .flush(state == DONE),
      .din  (din),
      .hit  (hit)
   );
   // frame FSM with payload shifter; DONE is a single unconditional cycle
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= HUNT;
         cnt       <= '0;
         data_sr   <= '0;
         dout      <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            HUNT: if (en && hit) begin
               state <= DATA;
               cnt   <= '0;
            end
            DATA: if (en) begin
               data_sr <= {data_sr[DATA_W-2:0], din};
               cnt     <= cnt == LAST ? '0 : cnt + 1'b1;
               if (cnt == LAST) begin
                  dout  <= {data_sr[DATA_W-2:0], din};
                  state <= DONE;
               end
            end
            DONE: begin
               frame_cnt <= frame_cnt + 8'd1;
               state     <= HUNT;
            end
            default: state <= HUNT;
         endcase
      end
   end
endmodule
